// File: rtl/multdiv_unit.sv
// Iterative 32-bit signed multiplier / divider: shift-add multiply, restoring divide.
// Fixed latency: resultRDY pulses one cycle, 33 cycles after the start edge.
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]      cnt;
  logic               op_div, neg;
  logic [2*WIDTH-1:0] mcand, acc;
  logic [WIDTH:0]     mplier, dvsr, rem;
  logic [WIDTH-1:0]   quo;

  logic start, last;
  assign start = ctrl_MULT | ctrl_DIV;
  assign last  = (cnt == CW'(WIDTH));

  // 33-bit magnitudes so that |0x80000000| is representable
  logic [WIDTH:0] a_ext, b_ext, mag_a, mag_b;
  assign a_ext = {data_operandA[WIDTH-1], data_operandA};
  assign b_ext = {data_operandB[WIDTH-1], data_operandB};
  assign mag_a = a_ext[WIDTH] ? -a_ext : a_ext;
  assign mag_b = b_ext[WIDTH] ? -b_ext : b_ext;

  // Restoring divide step: shift next dividend bit into the partial remainder
  logic [WIDTH+1:0] rem_sh, rem_sub;
  logic             rem_ge;
  assign rem_sh  = {rem, quo[WIDTH-1]};
  assign rem_sub = rem_sh - {1'b0, dvsr};
  assign rem_ge  = (rem_sh >= {1'b0, dvsr});

  // Final sign fix-up and overflow detection
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH:0]     prod_top;
  logic               mult_ovf;
  assign prod     = neg ? -acc : acc;
  assign quo_s    = neg ? -quo : quo;
  assign prod_top = prod[2*WIDTH-1:WIDTH-1];
  assign mult_ovf = !((&prod_top) | ~(|prod_top));

  logic unused_bits;
  assign unused_bits = ^{mag_a[WIDTH], rem_sub[WIDTH+1], rem_sh[WIDTH+1]};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (!start && last) state_nxt = DONE;
      DONE:    state_nxt = start ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign data_resultRDY = (state == DONE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt            <= '0;
      op_div         <= 1'b0;
      neg            <= 1'b0;
      mcand          <= '0;
      acc            <= '0;
      mplier         <= '0;
      dvsr           <= '0;
      rem            <= '0;
      quo            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (start) begin
      // Multiply wins when both commands arrive together
      cnt    <= '0;
      op_div <= !ctrl_MULT;
      neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      mcand  <= {{(WIDTH-1){1'b0}}, mag_a};
      acc    <= '0;
      mplier <= mag_b;
      dvsr   <= mag_b;
      rem    <= '0;
      quo    <= mag_a[WIDTH-1:0];
    end else if (state == BUSY) begin
      if (!last) begin
        cnt <= cnt + 1'b1;
        if (op_div) begin
          rem <= rem_ge ? rem_sub[WIDTH:0] : rem_sh[WIDTH:0];
          quo <= {quo[WIDTH-2:0], rem_ge};
        end else begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
        end
      end else if (op_div) begin
        data_result    <= (dvsr == '0) ? '0 : quo_s;
        data_exception <= (dvsr == '0);
      end else begin
        data_result    <= prod[WIDTH-1:0];
        data_exception <= mult_ovf;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed self-checking bench for multdiv_unit: mult/div vectors, back-to-back,
// restart mid-operation and reset mid-operation.
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;

  int passed = 0;
  int total  = 0;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock(clock), .resetn(resetn),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY)
  );

  always #5 clock = ~clock;

  // mode: 0 mult, 1 div, 2 both commands high. Operands are scrambled after the start edge.
  task automatic run_op(input int mode, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output logic exc,
                        output bit held);
    logic [31:0] prev;
    prev = data_result;
    held = 1'b1;
    @(posedge clock); #1;
    data_operandA = a; data_operandB = b;
    ctrl_MULT = (mode != 1); ctrl_DIV = (mode != 0);
    @(posedge clock); #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = ~a; data_operandB = b + 32'd3;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clock); #1;
      if (data_resultRDY) begin
        lat = k;
        break;
      end
      if (data_result !== prev) held = 1'b0;
    end
    res = data_result;
    exc = data_exception;
  endtask

  task automatic test_reset();
    resetn = 1'b0; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = 32'h1234_5678; data_operandB = 32'h9abc_def0;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if ({data_result, data_exception, data_resultRDY} !== 34'h0)
      $display("FAIL reset_outputs: got %h/%b/%b want 0/0/0", data_result, data_exception, data_resultRDY);
    else passed++;
    resetn = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    total++;
    if (data_resultRDY !== 1'b0) $display("FAIL idle_rdy: got %b want 0", data_resultRDY);
    else passed++;
  endtask

  task automatic test_vectors(input string name, input int mode, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp_res, input logic exp_exc);
    int lat; logic [31:0] res; logic exc; bit held;
    run_op(mode, a, b, lat, res, exc, held);
    total++;
    if (lat !== 33) $display("FAIL %s latency: got %0d want 33", name, lat);
    else passed++;
    total++;
    if (res !== exp_res || exc !== exp_exc)
      $display("FAIL %s result: got %h exc %b want %h exc %b", name, res, exc, exp_res, exp_exc);
    else passed++;
    @(posedge clock); #1;
    total++;
    if (data_resultRDY !== 1'b0 || data_result !== exp_res)
      $display("FAIL %s after_rdy: rdy %b res %h want rdy 0 res %h", name, data_resultRDY, data_result, exp_res);
    else passed++;
  endtask

  task automatic test_mult();
    test_vectors("mult_3x-7",       0, 32'd3,          32'hFFFF_FFF9, 32'hFFFF_FFEB, 1'b0);
    test_vectors("mult_65536sq",    0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1);
    test_vectors("mult_min_x1",     0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0);
    test_vectors("mult_min_x-1",    0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    test_vectors("mult_-5x-6",      0, 32'hFFFF_FFFB,  32'hFFFF_FFFA, 32'd30,        1'b0);
    test_vectors("mult_46341sq",    0, 32'd46341,      32'd46341,     32'h8000_1219, 1'b1);
    test_vectors("both_high_mult",  2, 32'd6,          32'd7,         32'd42,        1'b0);
  endtask

  task automatic test_div();
    test_vectors("div_-7/2",        1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0);
    test_vectors("div_7/-2",        1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
    test_vectors("div_100/0",       1, 32'd100,        32'd0,         32'h0000_0000, 1'b1);
    test_vectors("div_min/-1",      1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    test_vectors("div_3/10",        1, 32'd3,          32'd10,        32'h0000_0000, 1'b0);
    test_vectors("div_-100/7",      1, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 1'b0);
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] res; logic exc; bit held;
    run_op(0, 32'd6, 32'd7, lat, res, exc, held);
    total++;
    if (lat !== 33 || res !== 32'd42 || exc !== 1'b0)
      $display("FAIL b2b_mult: lat %0d res %h exc %b want 33 2a 0", lat, res, exc);
    else passed++;
    run_op(1, 32'd42, 32'd6, lat, res, exc, held);
    total++;
    if (held !== 1'b1) $display("FAIL b2b_hold: result changed while busy, got %b want 1", held);
    else passed++;
    total++;
    if (lat !== 33 || res !== 32'd7 || exc !== 1'b0)
      $display("FAIL b2b_div: lat %0d res %h exc %b want 33 7 0", lat, res, exc);
    else passed++;
  endtask

  task automatic test_restart();
    int pulses, first;
    @(posedge clock); #1;
    data_operandA = 32'd5; data_operandB = 32'd5; ctrl_MULT = 1'b1;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    data_operandA = 32'd100; data_operandB = 32'd7; ctrl_DIV = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0; data_operandA = 32'd1; data_operandB = 32'd1;
    pulses = 0; first = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clock); #1;
      if (data_resultRDY) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    total++;
    if (pulses !== 1 || first !== 33)
      $display("FAIL restart_rdy: pulses %0d at %0d want 1 at 33", pulses, first);
    else passed++;
    total++;
    if (data_result !== 32'd14 || data_exception !== 1'b0)
      $display("FAIL restart_result: got %h exc %b want e exc 0", data_result, data_exception);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(posedge clock); #1;
    data_operandA = 32'd1000; data_operandB = 32'd1000; ctrl_MULT = 1'b1;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    repeat (5) @(posedge clock);
    #2;
    resetn = 1'b0;
    #1;
    total++;
    if ({data_result, data_exception, data_resultRDY} !== 34'h0)
      $display("FAIL reset_mid_outputs: got %h/%b/%b want 0/0/0", data_result, data_exception, data_resultRDY);
    else passed++;
    @(posedge clock); #1;
    resetn = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      if (data_resultRDY) pulses++;
    end
    total++;
    if (pulses !== 0 || data_result !== 32'h0)
      $display("FAIL reset_mid_no_rdy: pulses %0d res %h want 0 0", pulses, data_result);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_back_to_back();
    test_restart();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
